mdu_core: RTL
=============

MDU_CORE -- requirements
Module: mdu_core

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 Port clk  input  1  rising-edge clock.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port in_valid  input  1  operation request.
REQ-005 Port in_ready  output  1  core can accept a request.
REQ-006 Port funct3  input  3  RV M opcode: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 Port in_1  input  XLEN  x[rs1], multiplicand or dividend.
REQ-008 Port in_2  input  XLEN  x[rs2], multiplier or divisor.
REQ-009 Port flush  input  1  abort any in-flight or held operation.
REQ-010 Port out_valid  output  1  result available.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Port out_data  output  XLEN  result.
REQ-013 Port exception  output  1  divide-by-zero flag, qualified by out_valid.

Function
REQ-014 States IDLE, CALC, FIX, DONE; in_ready is high only in IDLE.
REQ-015 Request accepted on in_valid && in_ready; funct3 and operands are registered at acceptance and need not stay stable afterwards.
REQ-016 Normal path: IDLE -> CALC, with magnitudes and result sign computed at acceptance. CALC runs exactly XLEN iterations (shift-add multiply, restoring divide, one bit per cycle) -> FIX applies sign and selects the high/low half or quotient/remainder -> DONE.
REQ-017 Normal-path latency: out_valid rises XLEN+2 cycles after the acceptance edge.
REQ-018 Fast path IDLE -> DONE, out_valid one cycle after acceptance, for these cases:
- divisor zero: DIV/DIVU give all-ones; REM/REMU give in_1; exception=1.
- signed overflow (in_1 = MIN, in_2 = -1): DIV gives MIN; REM gives 0; exception=0.
REQ-019 MULHSU treats in_1 as signed and in_2 as unsigned. MULHU/DIVU/REMU are fully unsigned.
REQ-020 DONE holds out_data, exception and out_valid stable until out_ready. The handshake edge returns to IDLE; in_ready is high the next cycle, with no bypass.
REQ-021 exception is 0 whenever out_valid is 0.
REQ-022 flush in any state -> IDLE next cycle. It drops out_valid and discards the result; flush has priority over out_ready and in_valid that cycle.
REQ-023 Full 2*XLEN product and both quotient and remainder are retained after every completed normal-path operation (see REQ-026).

Reset
REQ-024 On rst: state IDLE, out_valid 0, out_data 0, exception 0, in_ready 1, iteration counter 0, reuse-valid flag cleared.
REQ-025 rst mid-operation abandons the operation silently; no result is emitted.

Configuration
REQ-026 Macro MDU_FUSE_EN, when defined:
- A reuse-valid flag and the last operands/type are stored.
- A request whose operands and signedness class match the last completed normal-path operation takes the fast path from the stored result. Pairs are MUL/MULH/MULHSU/MULHU vs. the stored product, DIV/REM and DIVU/REMU vs. the stored quotient/remainder.
- The flag is cleared by flush or rst.
REQ-027 Without MDU_FUSE_EN: no reuse storage, and every non-special request takes the normal path.

Structure
REQ-028 Shared package mdu_pkg holds:
- mdu_op_e enum for funct3 codes.
- mdu_state_e enum for the FSM.
- Helper constants derived from XLEN for MIN and all-ones.
REQ-029 Sub-module mdu_iter_unit holds the XLEN-cycle shift-add/restoring datapath and counter. mdu_core holds the handshake, FSM, special-case detection, sign fixup and fuse storage.

Verification
REQ-030 XLEN=32, MULH in_1=0x80000000, in_2=0x80000000 -> out_data 0x40000000 at cycle 34, exception 0.
REQ-031 DIV in_1=7, in_2=0 -> out_data 0xFFFFFFFF at cycle 1, exception 1; REM with the same operands -> 7.
REQ-032 DIV in_1=0x80000000, in_2=0xFFFFFFFF -> 0x80000000 at cycle 1. REM with the same operands -> 0. exception 0 for both.
REQ-033 DIV -20,3 -> 0xFFFFFFFA; hold out_ready low 5 cycles -> out_data stable, in_ready 0. Then REM -20,3 -> 0xFFFFFFFE, at cycle 1 with MDU_FUSE_EN defined and at cycle 34 without it.
REQ-034 flush 10 cycles into a DIVU -> no out_valid; in_ready 1 next cycle; a following MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE.
REQ-035 XLEN=64, MUL 0xFFFFFFFFFFFFFFFF,2 -> 0xFFFFFFFFFFFFFFFE at cycle 66; assert rst mid-CALC -> all outputs at reset values, no result.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared opcode/state enums and XLEN-derived constant helpers for the M-extension unit
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // Computed at 64 bits and truncated by the caller to its own XLEN.
    function automatic logic [63:0] xlen_min(input int xlen);
        return 64'(1) << (xlen - 1);
    endfunction

    function automatic logic [63:0] xlen_ones(input int xlen);
        return {64{1'b1}} >> (64 - xlen);
    endfunction

endpackage

// File: rtl/mdu_iter_unit.sv
// rtl/mdu_iter_unit.sv - one-bit-per-cycle shift-add multiplier / restoring divider on unsigned magnitudes
module mdu_iter_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic            last,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic            div_q, div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]   sum, rem_sh, trial;

    assign last = (cnt_q == CW'(XLEN - 1));
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Multiply: {hi,lo} ends as the product. Divide: lo ends as quotient, hi as remainder.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        sum    = {1'b0, hi_q} + {1'b0, opnd_q};
        rem_sh = {hi_q, lo_q[XLEN-1]};
        trial  = rem_sh - {1'b0, opnd_q};
        if (start) begin
            hi_d   = '0;
            lo_d   = is_div ? a_mag : b_mag;
            opnd_d = is_div ? b_mag : a_mag;
            div_d  = is_div;
            cnt_d  = '0;
        end else if (step) begin
            cnt_d = last ? '0 : cnt_q + CW'(1);
            if (div_q) begin
                if (!trial[XLEN]) begin
                    hi_d = trial[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = rem_sh[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
            end else if (lo_q[0]) begin
                {hi_d, lo_d} = {sum, lo_q[XLEN-1:1]};
            end else begin
                {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - RV M multiply/divide core: handshake, FSM, special cases, sign fixup; MDU_FUSE_EN enables result reuse
module mdu_core
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] in_1,
    input  logic [XLEN-1:0] in_2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            exception
);
    localparam logic [XLEN-1:0] MIN_V  = XLEN'(xlen_min(XLEN));
    localparam logic [XLEN-1:0] ONES_V = XLEN'(xlen_ones(XLEN));

    function automatic logic [XLEN-1:0] pick(input mdu_op_e op, input logic [2*XLEN-1:0] p,
                                             input logic [XLEN-1:0] q, input logic [XLEN-1:0] r);
        case (op)
            OP_MUL:                        return p[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  return p[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               return q;
            default:                       return r;
        endcase
    endfunction

    mdu_state_e      state_q, state_d;
    mdu_op_e         op_q, op_d, op_in;
    logic            a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d, exc_q, exc_d;

    logic            is_div_in, a_signed, b_signed, a_neg_in, b_neg_in;
    logic            div_zero, div_ovf, start, last, fuse_hit;
    logic [XLEN-1:0] a_mag, b_mag, hi, lo, quot_fix, rem_fix, fuse_res;
    logic [2*XLEN-1:0] prod_fix;

    assign op_in     = mdu_op_e'(funct3);
    assign is_div_in = funct3[2];
    assign a_signed  = funct3 inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign b_signed  = funct3 inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    assign a_neg_in  = a_signed & in_1[XLEN-1];
    assign b_neg_in  = b_signed & in_2[XLEN-1];
    assign a_mag     = a_neg_in ? -in_1 : in_1;
    assign b_mag     = b_neg_in ? -in_2 : in_2;
    assign div_zero  = is_div_in && (in_2 == '0);
    assign div_ovf   = (op_in == OP_DIV || op_in == OP_REM) && (in_1 == MIN_V) && (in_2 == ONES_V);

    // Remainder takes the dividend's sign; product and quotient take the XOR.
    assign prod_fix  = (a_neg_q ^ b_neg_q) ? -{hi, lo} : {hi, lo};
    assign quot_fix  = (a_neg_q ^ b_neg_q) ? -lo : lo;
    assign rem_fix   = a_neg_q ? -hi : hi;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign exception = exc_q;

    mdu_iter_unit #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .step   (state_q == ST_CALC),
        .is_div (is_div_in),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .last   (last),
        .hi     (hi),
        .lo     (lo)
    );

`ifdef MDU_FUSE_EN
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic              is_div;
        logic              a_s;
        logic              b_s;
        logic [2*XLEN-1:0] res;
    } fuse_t;

    fuse_t fuse_q, fuse_d;

    // Divide results are kept as {remainder, quotient} in the product slot.
    assign fuse_hit = fuse_q.valid && (fuse_q.a == in_1) && (fuse_q.b == in_2) &&
                      (fuse_q.is_div == is_div_in) && (fuse_q.a_s == a_signed) && (fuse_q.b_s == b_signed);
    assign fuse_res = pick(op_in, fuse_q.res, fuse_q.res[XLEN-1:0], fuse_q.res[2*XLEN-1:XLEN]);

    always_comb begin
        fuse_d = fuse_q;
        if (start) begin
            fuse_d.valid  = 1'b0;
            fuse_d.a      = in_1;
            fuse_d.b      = in_2;
            fuse_d.is_div = is_div_in;
            fuse_d.a_s    = a_signed;
            fuse_d.b_s    = b_signed;
        end
        if (state_q == ST_FIX) begin
            fuse_d.valid = 1'b1;
            fuse_d.res   = fuse_q.is_div ? {rem_fix, quot_fix} : prod_fix;
        end
        if (flush) fuse_d.valid = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fuse_q <= '0;
        else     fuse_q <= fuse_d;
    end
`else
    assign fuse_hit = 1'b0;
    assign fuse_res = '0;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        exc_d       = exc_q;
        start       = 1'b0;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                op_d    = op_in;
                a_neg_d = a_neg_in;
                b_neg_d = b_neg_in;
                if (div_zero) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    exc_d       = 1'b1;
                    out_data_d  = funct3[1] ? in_1 : ONES_V;
                end else if (div_ovf) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = funct3[1] ? '0 : MIN_V;
                end else if (fuse_hit) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = fuse_res;
                end else begin
                    state_d = ST_CALC;
                    start   = 1'b1;
                end
            end
            ST_CALC: if (last) state_d = ST_FIX;
            ST_FIX: begin
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                out_data_d  = pick(op_q, prod_fix, quot_fix, rem_fix);
            end
            default: if (out_ready) begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                exc_d       = 1'b0;
            end
        endcase
        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            exc_d       = 1'b0;
            out_data_d  = '0;
            start       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            exc_q       <= exc_d;
        end
    end

endmodule
